// File: rtl/fchan_gpt_check.sv
// Gates-per-trig checker: counts gates since the last trig and raises a
// sticky, clearable error on short, long or overlapping blocks.
module fchan_gpt_check #(
  parameter int len = 16,
  parameter int lw  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_gate,
  input  logic a_trig,
  input  logic err_clr,
  output logic time_err
);

  localparam logic [lw:0] len_c = (lw+1)'(len);

  logic [lw:0] gcnt;
  logic        armed;
  logic        err_set;

  // Violation detect: block length mismatch at trig, gate past the block end,
  // or a gate landing on the trig itself.
  always_comb begin
    err_set = 1'b0;
    if (a_trig && armed && (gcnt != len_c))
      err_set = 1'b1;
    if (a_gate && !a_trig && armed && (gcnt == len_c))
      err_set = 1'b1;
    if (a_gate && a_trig)
      err_set = 1'b1;
  end

  // Gate counter, arm flag and sticky error; a new violation beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt     <= '0;
      armed    <= 1'b0;
      time_err <= 1'b0;
    end else begin
      if (a_trig) begin
        gcnt  <= '0;
        armed <= 1'b1;
      end else if (a_gate && (gcnt != len_c)) begin
        gcnt <= gcnt + (lw+1)'(1);
      end

      if (err_set)
        time_err <= 1'b1;
      else if (err_clr)
        time_err <= 1'b0;
    end
  end

endmodule

// File: rtl/fchan_subset_dec.sv
// Channel-subset selector with block decimation. Forwards the channels
// enabled by the mask latched at trig, on every (dec+1)-th block only.
module fchan_subset_dec #(
  parameter  int dw  = 20,
  parameter  int len = 16,
  parameter  int dcw = 8,
  localparam int lw  = $clog2(len)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [len-1:0]       keep,
  input  logic [dcw-1:0]       dec,
  input  logic                 err_clr,
  input  logic signed [dw-1:0] a_data,
  input  logic                 a_gate,
  input  logic                 a_trig,
  output logic signed [dw-1:0] o_data,
  output logic                 o_gate,
  output logic                 o_trig,
  output logic [lw-1:0]        o_chan,
  output logic [lw:0]          n_keep,
  output logic                 time_err
);

  localparam logic [lw:0] len_c = (lw+1)'(len);

  logic [len-1:0] mask;
  logic [len-1:0] mask_nxt;
  logic [len-1:0] live;
  logic [dcw-1:0] dcnt;
  logic [lw:0]    chan;
  logic           retain;

  function automatic logic [lw:0] popcnt(input logic [len-1:0] v);
    logic [lw:0] c;
    c = '0;
    for (int unsigned i = 0; i < len; i++)
      c = c + (lw+1)'(v[i]);
    return c;
  endfunction

  // Mask as seen this cycle: keep on a trig, otherwise the latched copy.
  // Reload and popcount both read through it, so they equal keep at trig.
  always_comb begin
    mask_nxt = a_trig ? keep : mask;
    retain   = (dcnt == '0);
  end

  // Block sequencing, channel walk and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      live   <= '0;
      dcnt   <= '0;
      chan   <= '0;
      o_data <= '0;
      o_gate <= 1'b0;
      o_trig <= 1'b0;
      o_chan <= '0;
      n_keep <= '0;
    end else begin
      o_data <= a_data;
      o_gate <= 1'b0;
      o_trig <= 1'b0;
      if (a_trig) begin
        mask   <= keep;
        live   <= retain ? mask_nxt : '0;
        chan   <= '0;
        o_trig <= retain;
        dcnt   <= retain ? dec : dcnt - dcw'(1);
        if (retain)
          n_keep <= popcnt(mask_nxt);
      end else if (a_gate) begin
        o_gate <= live[len-1];
        o_chan <= chan[lw-1:0];
        live   <= {live[len-2:0], 1'b0};
        if (chan != len_c)
          chan <= chan + (lw+1)'(1);
      end
    end
  end

  fchan_gpt_check #(
    .len (len),
    .lw  (lw)
  ) u_gpt_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_gate   (a_gate),
    .a_trig   (a_trig),
    .err_clr  (err_clr),
    .time_err (time_err)
  );

endmodule

// File: tb/tb_fchan_subset_dec.sv
// Directed bench for fchan_subset_dec: vector table plus a reset sequence.
module tb_fchan_subset_dec;

  localparam int dw  = 20;
  localparam int len = 16;
  localparam int dcw = 8;
  localparam int lw  = 4;

  logic                 clk;
  logic                 rst_n;
  logic [len-1:0]       keep;
  logic [dcw-1:0]       dec;
  logic                 err_clr;
  logic signed [dw-1:0] a_data;
  logic                 a_gate;
  logic                 a_trig;
  logic signed [dw-1:0] o_data;
  logic                 o_gate;
  logic                 o_trig;
  logic [lw-1:0]        o_chan;
  logic [lw:0]          n_keep;
  logic                 time_err;

  int checks;
  int errors;

  typedef struct {
    logic           trig;
    logic           gate;
    logic           clr;
    logic [len-1:0] keep;
    logic [dcw-1:0] dec;
    logic           e_gate;
    logic           e_trig;
    logic           e_err;
    logic [lw-1:0]  e_chan;
    logic [lw:0]    e_nk;
  } vec_t;

  vec_t           vq[$];
  logic [len-1:0] cur_keep;
  logic [dcw-1:0] cur_dec;

  fchan_subset_dec #(
    .dw  (dw),
    .len (len),
    .dcw (dcw)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .keep     (keep),
    .dec      (dec),
    .err_clr  (err_clr),
    .a_data   (a_data),
    .a_gate   (a_gate),
    .a_trig   (a_trig),
    .o_data   (o_data),
    .o_gate   (o_gate),
    .o_trig   (o_trig),
    .o_chan   (o_chan),
    .n_keep   (n_keep),
    .time_err (time_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit t, input bit g, input bit c, input bit eg, input bit et,
                     input bit ee, input int ch, input int nk);
    vec_t v;
    v.trig   = t;
    v.gate   = g;
    v.clr    = c;
    v.keep   = cur_keep;
    v.dec    = cur_dec;
    v.e_gate = eg;
    v.e_trig = et;
    v.e_err  = ee;
    v.e_chan = lw'(ch);
    v.e_nk   = (lw+1)'(nk);
    vq.push_back(v);
  endtask

  initial begin
    logic signed [dw-1:0] dval;
    bit r;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    keep     = '0;
    dec      = '0;
    err_clr  = 1'b0;
    a_data   = '0;
    a_gate   = 1'b0;
    a_trig   = 1'b0;

    // Block with keep=A000: channels 0 and 2 only.
    cur_keep = 16'hA000;
    cur_dec  = 8'd0;
    add(1, 0, 0, 0, 1, 0, 0, 2);
    for (int g = 0; g < 16; g++) add(0, 1, 0, (g == 0 || g == 2), 0, 0, g, 0);

    // dec=2 over six full blocks: blocks 0 and 3 retained.
    cur_keep = 16'hFFFF;
    cur_dec  = 8'd2;
    for (int b = 0; b < 6; b++) begin
      r = (b % 3 == 0);
      add(1, 0, 0, 0, r, 0, 0, 16);
      for (int g = 0; g < 16; g++) add(0, 1, 0, r, 0, 0, g, 0);
    end
    cur_dec = 8'd0;

    // keep changes mid-block: only the next block sees it.
    cur_keep = 16'hFFFF;
    add(1, 0, 0, 0, 1, 0, 0, 16);
    for (int g = 0; g < 16; g++) begin
      if (g == 5) cur_keep = 16'h0001;
      add(0, 1, 0, 1, 0, 0, g, 0);
    end
    add(1, 0, 0, 0, 1, 0, 0, 1);
    for (int g = 0; g < 16; g++) add(0, 1, 0, (g == 15), 0, 0, g, 0);

    // Short block, clear, then a 17th gate.
    add(1, 0, 0, 0, 1, 0, 0, 1);
    for (int g = 0; g < 15; g++) add(0, 1, 0, 0, 0, 0, g, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    for (int g = 0; g < 16; g++) add(0, 1, 0, (g == 15), 0, 0, g, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Gate coincident with trig: trig wins, gate dropped, error set.
    add(1, 1, 0, 0, 1, 1, 0, 1);
    for (int g = 0; g < 16; g++) add(0, 1, 0, (g == 15), 0, 1, g, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_gate", -1, 32'(o_gate), 32'd0);
    chk("reset_o_trig", -1, 32'(o_trig), 32'd0);
    chk("reset_n_keep", -1, 32'(n_keep), 32'd0);
    chk("reset_err",    -1, 32'(time_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      dval    = dw'(i * 37 - 500);
      a_trig  = vq[i].trig;
      a_gate  = vq[i].gate;
      err_clr = vq[i].clr;
      keep    = vq[i].keep;
      dec     = vq[i].dec;
      a_data  = dval;
      @(posedge clk);
      #1;
      chk("o_gate", i, 32'(o_gate), 32'(vq[i].e_gate));
      chk("o_trig", i, 32'(o_trig), 32'(vq[i].e_trig));
      chk("time_err", i, 32'(time_err), 32'(vq[i].e_err));
      chk("o_data", i, 32'(o_data), 32'(dval));
      if (vq[i].e_gate) chk("o_chan", i, 32'(o_chan), 32'(vq[i].e_chan));
      if (vq[i].e_trig) chk("n_keep", i, 32'(n_keep), 32'(vq[i].e_nk));
    end

    // Reset mid-block, then a fresh first trig.
    @(negedge clk);
    a_gate = 1'b0; err_clr = 1'b0; a_trig = 1'b1; keep = 16'hFFFF; dec = '0;
    @(posedge clk);
    #1;
    chk("r_trig", 0, 32'(o_trig), 32'd1);
    chk("r_err0", 0, 32'(time_err), 32'd0);
    for (int g = 0; g < 7; g++) begin
      @(negedge clk);
      a_trig = 1'b0; a_gate = 1'b1; a_data = dw'(1000 + g);
      @(posedge clk);
      #1;
      chk("r_gate", g, 32'(o_gate), 32'd1);
    end
    @(negedge clk);
    a_data = 20'sh7FFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_o_gate", 7, 32'(o_gate), 32'd0);
    chk("async_o_data", 7, 32'(o_data), 32'd0);
    chk("async_o_chan", 7, 32'(o_chan), 32'd0);
    chk("async_n_keep", 7, 32'(n_keep), 32'd0);
    chk("async_o_trig", 7, 32'(o_trig), 32'd0);
    chk("async_err",    7, 32'(time_err), 32'd0);
    @(negedge clk);
    a_gate = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    a_trig = 1'b1; keep = 16'h0001;
    @(posedge clk);
    #1;
    chk("post_rst_trig", 0, 32'(o_trig), 32'd1);
    chk("post_rst_nk",   0, 32'(n_keep), 32'd1);
    chk("post_rst_err",  0, 32'(time_err), 32'd0);
    @(negedge clk);
    a_trig = 1'b0; a_gate = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gate0", 0, 32'(o_gate), 32'd0);
    chk("post_rst_err1",  0, 32'(time_err), 32'd0);
    @(negedge clk);
    a_gate = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
